// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Purpose  : Iterative shift/rotate unit (SLL, SRL, SRA, ROL, ROR) that moves
//            an XLEN-bit operand by at most STEP bits per cycle, with
//            valid/ready handshakes on both the request and the result side.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter #(
  parameter  int XLEN = 32,
  parameter  int STEP = 8,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [SHW-1:0]  shamt,
  input  logic [XLEN-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_err
);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Operation encodings
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b110;

  // Distances are carried one bit wider than SHW so that STEP==XLEN fits.
  localparam logic [SHW:0] C_XLEN = (SHW+1)'(XLEN);
  localparam logic [SHW:0] C_STEP = (SHW+1)'(STEP);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] data_q,  data_d;
  logic [SHW-1:0]  rem_q,   rem_d;
  logic [2:0]      op_q,    op_d;
  logic            err_q,   err_d;
  logic            sign_q,  sign_d;

  logic            w_op_illegal;
  logic            w_last_step;
  logic [SHW:0]    w_dist;
  logic [SHW:0]    w_back;
  logic [XLEN-1:0] w_step_res;

  assign w_op_illegal = (op != OP_SLL) && (op != OP_SRL) && (op != OP_SRA) &&
                        (op != OP_ROL) && (op != OP_ROR);
  // The final step is the one that consumes whatever distance is left.
  assign w_last_step  = ({1'b0, rem_q} <= C_STEP);
  assign w_dist       = ({1'b0, rem_q} < C_STEP) ? {1'b0, rem_q} : C_STEP;
  // Complementary distance for the wrap/fill half; w_dist is never 0 in SHIFT.
  assign w_back       = C_XLEN - w_dist;

  // One iteration of the latched operation by w_dist bits.
  always_comb begin
    w_step_res = data_q;
    case (op_q)
      OP_SLL:  w_step_res = data_q << w_dist;
      OP_SRL:  w_step_res = data_q >> w_dist;
      // Sign fill comes from the bit latched at accept, which always equals
      // the current MSB because every SRA step refills with that same bit.
      OP_SRA:  w_step_res = ({XLEN{sign_q}} << w_back) | (data_q >> w_dist);
      OP_ROL:  w_step_res = (data_q << w_dist) | (data_q >> w_back);
      OP_ROR:  w_step_res = (data_q >> w_dist) | (data_q << w_back);
      default: w_step_res = data_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_op_illegal || (shamt == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (w_last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: latch on accept, iterate while shifting
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    op_d   = op_q;
    err_d  = err_q;
    sign_d = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = data_in;
          rem_d  = shamt;
          op_d   = op;
          err_d  = w_op_illegal;
          sign_d = data_in[XLEN-1];
        end
      end
      ST_SHIFT: begin
        data_d = w_step_res;
        rem_d  = rem_q - w_dist[SHW-1:0];
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= '0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      err_q  <= err_d;
      sign_q <= sign_d;
    end
  end

  // Outputs are pure decodes of registered state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    result    = data_q;
    out_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shifter
// Purpose  : Scoreboard bench for seq_shifter (XLEN=32, STEP=8): directed
//            requests push expected result/err/latency; a monitor compares
//            whenever the DUT presents a result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b110;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_err;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   prev_hold = 1'b0;

  seq_shifter #(.XLEN(32), .STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .shamt     (shamt),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compare every cycle a result is presented; pop on handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h with nothing expected", result);
      end else begin
        if (!prev_hold) check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
        check("result", result, sb[0].res);
        check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
        if (out_ready) e = sb.pop_front();
      end
      prev_hold = !out_ready;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Wait for in_ready, present one request, optionally record its expectation
  task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b1;
    op       = o;
    shamt    = s;
    data_in  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back('{res: er, err: ee, lat: lat, acc: cyc});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'b000;
    shamt     = 5'd0;
    data_in   = 32'h0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
    rst = 1'b0;

    // Directed vectors: op, shamt, data, expected result, err, latency
    issue(OP_SLL, 5'd5,  32'h00000001, 32'h00000020, 1'b0, 2, 1'b1);
    issue(OP_SRA, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5, 1'b1);
    issue(OP_SRL, 5'd31, 32'h80000000, 32'h00000001, 1'b0, 5, 1'b1);
    issue(OP_ROR, 5'd4,  32'h000000F1, 32'h1000000F, 1'b0, 2, 1'b1);
    issue(OP_ROL, 5'd1,  32'h80000001, 32'h00000003, 1'b0, 2, 1'b1);
    issue(OP_SRA, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    issue(3'b001, 5'd9,  32'h12345678, 32'h12345678, 1'b1, 1, 1'b1);
    issue(OP_ROL, 5'd12, 32'h12345678, 32'h45678123, 1'b0, 3, 1'b1);
    issue(OP_SRA, 5'd20, 32'hF0000000, 32'hFFFFFF00, 1'b0, 4, 1'b1);
    issue(OP_SLL, 5'd8,  32'h000000AB, 32'h0000AB00, 1'b0, 2, 1'b1);
    issue(OP_ROR, 5'd16, 32'h1234ABCD, 32'hABCD1234, 1'b0, 3, 1'b1);
    issue(3'b111, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1, 1'b1);
    issue(OP_ROL, 5'd31, 32'h00000001, 32'h80000000, 1'b0, 5, 1'b1);
    issue(OP_SRL, 5'd17, 32'hFFFFFFFF, 32'h00007FFF, 1'b0, 4, 1'b1);
    wait_idle();

    // Backpressure: hold the result while a request is pulsed at the input
    out_ready = 1'b0;
    issue(OP_SLL, 5'd5, 32'h00000001, 32'h00000020, 1'b0, 2, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (3) begin
      in_valid = 1'b1;
      op       = OP_SRL;
      shamt    = 5'd3;
      data_in  = 32'h0000FFFF;
      @(posedge clk); #1;
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("bp_no_ghost_valid", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // Reset during the second step of a 20-bit SLL discards it
    issue(OP_SLL, 5'd20, 32'h00000001, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result",    result,             32'd0);
    issue(OP_SLL, 5'd20, 32'h00000003, 32'h00300000, 1'b0, 4, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
